// File: rtl/gcd_controller.sv
// Control FSM for the subtract-based 4-bit GCD datapath: start/busy/done handshake and iteration count.
// Optional runaway-loop timeout (ERR state) enabled by defining GCD_TIMEOUT_EN.
module gcd_controller #(
  parameter int unsigned MAX_ITER = 16,
  parameter int unsigned CNT_W    = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             x_neq_y,
  input  logic             x_lt_y,
  output logic             x_sel,
  output logic             y_sel,
  output logic             x_ld,
  output logic             y_ld,
  output logic             d_ld,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [CNT_W-1:0] iter_count
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_CHECK = 3'd2,
    S_SUBX  = 3'd3,
    S_SUBY  = 3'd4,
    S_STORE = 3'd5,
`ifdef GCD_TIMEOUT_EN
    S_DONE  = 3'd6,
    S_ERR   = 3'd7
`else
    S_DONE  = 3'd6
`endif
  } state_t;

  // The counter must be able to reach MAX_ITER for the timeout compare to fire.
  if (MAX_ITER > (2 ** CNT_W) - 1) begin : g_cfg_check
    $error("gcd_controller: CNT_W too narrow to hold MAX_ITER");
  end

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_iter;
  logic             w_sat;
  logic             w_step;

  assign w_sat      = &r_iter;
  assign w_step     = (r_state == S_SUBX) || (r_state == S_SUBY);
  assign iter_count = r_iter;

`ifdef GCD_TIMEOUT_EN
  logic w_at_max;
  assign w_at_max = (r_iter == CNT_W'(MAX_ITER));
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_iter  <= '0;
    end else begin
      r_state <= w_next;
      if ((r_state == S_IDLE) && start) begin
        r_iter <= '0;
      end else if (w_step && !w_sat) begin
        r_iter <= r_iter + 1'b1;
      end
    end
  end

  // Moore decode: strobes depend on r_state only; flags steer w_next alone.
  always_comb begin
    w_next = S_IDLE;
    x_sel  = 1'b0;
    y_sel  = 1'b0;
    x_ld   = 1'b0;
    y_ld   = 1'b0;
    d_ld   = 1'b0;
    busy   = 1'b0;
    done   = 1'b0;
    err    = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_next = start ? S_LOAD : S_IDLE;
      end
      S_LOAD: begin
        x_ld   = 1'b1;
        y_ld   = 1'b1;
        busy   = 1'b1;
        w_next = S_CHECK;
      end
      S_CHECK: begin
        busy = 1'b1;
        if (!x_neq_y) begin
          w_next = S_STORE;
`ifdef GCD_TIMEOUT_EN
        end else if (w_at_max) begin
          w_next = S_ERR;
`endif
        end else if (x_lt_y) begin
          w_next = S_SUBY;
        end else begin
          w_next = S_SUBX;
        end
      end
      S_SUBX: begin
        x_sel  = 1'b1;
        x_ld   = 1'b1;
        busy   = 1'b1;
        w_next = S_CHECK;
      end
      S_SUBY: begin
        y_sel  = 1'b1;
        y_ld   = 1'b1;
        busy   = 1'b1;
        w_next = S_CHECK;
      end
      S_STORE: begin
        d_ld   = 1'b1;
        busy   = 1'b1;
        w_next = S_DONE;
      end
      S_DONE: begin
        done   = 1'b1;
        busy   = 1'b1;
        w_next = S_IDLE;
      end
`ifdef GCD_TIMEOUT_EN
      S_ERR: begin
        done   = 1'b1;
        err    = 1'b1;
        busy   = 1'b1;
        w_next = S_IDLE;
      end
`endif
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_gcd_controller.sv
// Self-checking bench for gcd_controller with a behavioural 4-bit datapath and a done-event scoreboard.
module tb_gcd_controller;

  localparam int unsigned MAX_ITER = 16;
  localparam int unsigned CNT_W    = 5;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic             x_neq_y;
  logic             x_lt_y;
  logic             x_sel;
  logic             y_sel;
  logic             x_ld;
  logic             y_ld;
  logic             d_ld;
  logic             busy;
  logic             done;
  logic             err;
  logic [CNT_W-1:0] iter_count;

  logic [3:0] xin   = 4'd0;
  logic [3:0] yin   = 4'd0;
  logic [3:0] r_x   = 4'd0;
  logic [3:0] r_y   = 4'd0;
  logic [3:0] r_res = 4'd0;

  always #5 clk = ~clk;

  gcd_controller #(
    .MAX_ITER (MAX_ITER),
    .CNT_W    (CNT_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .x_neq_y    (x_neq_y),
    .x_lt_y     (x_lt_y),
    .x_sel      (x_sel),
    .y_sel      (y_sel),
    .x_ld       (x_ld),
    .y_ld       (y_ld),
    .d_ld       (d_ld),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .iter_count (iter_count)
  );

  // Datapath: registers capture on the falling edge, flags are combinational.
  assign x_neq_y = (r_x != r_y);
  assign x_lt_y  = (r_x < r_y);
  always @(negedge clk) begin
    if (x_ld) r_x <= x_sel ? (r_x - r_y) : xin;
    if (y_ld) r_y <= y_sel ? (r_y - r_x) : yin;
    if (d_ld) r_res <= r_x;
  end

  typedef struct {
    int done_edge;
    int res;
    int iters;
    int err;
  } exp_t;

  exp_t sb[$];
  int   edge_n    = 0;
  int   n_chk     = 0;
  int   n_fail    = 0;
  int   n_done    = 0;
  int   n_dld     = 0;
  int   last_res  = 0;
  logic prev_done = 1'b0;

  always @(posedge clk) edge_n++;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int gcd_ref(input int a, input int b);
    int t;
    while (b != 0) begin
      t = a % b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (d_ld) n_dld++;
    if (prev_done) check_eq("done_width", done, 0);
    prev_done = done;
    if (done) begin
      n_done++;
      if (sb.size() == 0) begin
        check_eq("spurious_done", 1, 0);
      end else begin
        e = sb.pop_front();
        check_eq("done_edge", edge_n, e.done_edge);
        check_eq("iter_count", int'(iter_count), e.iters);
        check_eq("err", int'(err), e.err);
        check_eq("result", int'(r_res), e.res);
        check_eq("busy_at_done", int'(busy), 1);
      end
    end
  end

  task automatic wait_drain(input int budget);
    for (int i = 0; i < budget && sb.size() != 0; i++) @(posedge clk);
    #2;
    if (sb.size() != 0) begin
      check_eq("drain_timeout", sb.size(), 0);
      sb.delete();
    end
  endtask

  task automatic run_gcd(input int a, input int b);
    int ea = a;
    int eb = b;
    int k  = 0;
    int e  = 0;
    int res;
    int off;
    while (ea != eb) begin
`ifdef GCD_TIMEOUT_EN
      if (k == MAX_ITER) begin
        e = 1;
        break;
      end
`endif
      if (ea < eb) eb -= ea;
      else         ea -= eb;
      k++;
    end
    res = e ? last_res : gcd_ref(a, b);
    off = e ? (2 * k + 2) : (2 * k + 3);
    @(posedge clk);
    #1;
    xin   = 4'(a);
    yin   = 4'(b);
    start = 1'b1;
    sb.push_back('{done_edge: edge_n + 1 + off, res: res, iters: k, err: e});
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_drain(200);
    last_res = res;
  endtask

  task automatic check_quiet(input string tag);
    check_eq(tag, int'({x_sel, y_sel, x_ld, y_ld, d_ld, busy, done, err}), 0);
    check_eq({tag, "_iter"}, int'(iter_count), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    int dl0;
    int s0;
    reset = 1'b1;
    start = 1'b0;
    #12;
    check_quiet("reset_state");
    @(negedge clk);
    reset = 1'b0;

    run_gcd(12, 8);
    repeat (3) @(posedge clk);
    #1;
    check_eq("iter_hold_idle", int'(iter_count), 2);
    check_eq("idle_busy", int'(busy), 0);

    run_gcd(7, 7);
    run_gcd(15, 1);

`ifdef GCD_TIMEOUT_EN
    dl0 = n_dld;
    run_gcd(5, 0);
    check_eq("err_no_dld", n_dld - dl0, 0);
`else
    begin
      int busy_low = 0;
      int err_seen = 0;
      @(posedge clk);
      #1;
      xin   = 4'd5;
      yin   = 4'd0;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      for (int i = 0; i < 100; i++) begin
        @(posedge clk);
        #1;
        if (!busy) busy_low++;
        if (err) err_seen++;
      end
      check_eq("zero_busy_held", busy_low, 0);
      check_eq("zero_err_tied", err_seen, 0);
      check_eq("iter_saturate", int'(iter_count), 31);
      reset = 1'b1;
      #1;
      check_quiet("zero_reset");
      @(negedge clk);
      reset = 1'b0;
    end
`endif

    // start pulse during a run must be ignored
    d0 = n_done;
    @(posedge clk);
    #1;
    xin   = 4'd12;
    yin   = 4'd8;
    start = 1'b1;
    sb.push_back('{done_edge: edge_n + 1 + 7, res: 4, iters: 2, err: 0});
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    wait_drain(100);
    repeat (6) @(posedge clk);
    #2;
    check_eq("busy_start_ignored", n_done - d0, 1);

    // start held for 20 edges: accepts every 9 edges (7 busy + DONE + one IDLE)
    d0 = n_done;
    @(posedge clk);
    #1;
    start = 1'b1;
    s0 = edge_n + 1;
    for (int j = 0; j < 3; j++)
      sb.push_back('{done_edge: s0 + 9 * j + 7, res: 4, iters: 2, err: 0});
    repeat (20) @(posedge clk);
    #1;
    start = 1'b0;
    wait_drain(100);
    repeat (6) @(posedge clk);
    #2;
    check_eq("held_start_runs", n_done - d0, 3);

    // asynchronous reset while in SUBX
    d0 = n_done;
    @(posedge clk); #1; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #3;
    check_eq("in_subx", int'({x_sel, x_ld}), 3);
    reset = 1'b1;
    #1;
    check_quiet("async_reset");
    @(posedge clk);
    #1;
    check_quiet("reset_next_cycle");
    @(negedge clk);
    reset = 1'b0;
    repeat (12) @(posedge clk);
    #2;
    check_eq("reset_no_done", n_done - d0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
